// File: rtl/rv_mem_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus.
// A grant is held for the whole transfer, with an idle cycle between transfers and a watchdog.
module rv_mem_arbiter #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        busy,
    output logic        grant,
    output logic        timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic             grant_q, grant_nxt;
    logic             prio_q, prio_nxt;
    logic [CNT_W-1:0] wd_cnt;

    logic        g_valid, g_instr;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_wstrb;
    logic        wd_expire;
    logic        done;
    logic        tmo;
    logic [31:0] done_rdata;

    assign g_valid = grant_q ? m1_valid : m0_valid;
    assign g_instr = grant_q ? m1_instr : m0_instr;
    assign g_addr  = grant_q ? m1_addr  : m0_addr;
    assign g_wdata = grant_q ? m1_wdata : m0_wdata;
    assign g_wstrb = grant_q ? m1_wstrb : m0_wstrb;

    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt == CNT_LAST);

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        prio_nxt  = prio_q;
        s_valid   = 1'b0;
        s_instr   = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    grant_nxt = (m0_valid && m1_valid) ? prio_q : m1_valid;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy    = 1'b1;
                s_valid = g_valid;
                s_instr = g_instr;
                s_addr  = g_addr;
                s_wdata = g_wdata;
                s_wstrb = g_wstrb;
                // A slave completion beats both an abort and the watchdog.
                if (s_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                    prio_nxt  = ~grant_q;
                end else if (!g_valid) begin
                    state_nxt = IDLE;
                end else if (wd_expire) begin
                    done      = 1'b1;
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                    prio_nxt  = ~grant_q;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign done_rdata  = s_ready ? s_rdata : TIMEOUT_RDATA;
    assign m0_ready    = done && !grant_q;
    assign m1_ready    = done &&  grant_q;
    assign m0_rdata    = m0_ready ? done_rdata : '0;
    assign m1_rdata    = m1_ready ? done_rdata : '0;
    assign timeout_err = tmo;
    assign grant       = grant_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            prio_q  <= prio_nxt;
            if (state == IDLE)
                wd_cnt <= '0;
            else if (!s_ready && wd_cnt != CNT_MAX)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: directed vector table, corner-case sequences
// and a randomized run against a transaction-level reference model.
module tb_rv_mem_arbiter;

    localparam int          TMO = 8;
    localparam logic [31:0] TRD = 32'hDEAD_BEEF;

    logic        clk;
    logic        resetn;
    logic        mv[2];
    logic        mi[2];
    logic [31:0] ma[2];
    logic [31:0] mw[2];
    logic [3:0]  ms[2];
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        m0_ready, m1_ready, s_valid, s_instr, busy, grant, timeout_err;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    rv_mem_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_RDATA (TRD)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m0_valid   (mv[0]),
        .m0_instr   (mi[0]),
        .m0_addr    (ma[0]),
        .m0_wdata   (mw[0]),
        .m0_wstrb   (ms[0]),
        .m0_ready   (m0_ready),
        .m0_rdata   (m0_rdata),
        .m1_valid   (mv[1]),
        .m1_instr   (mi[1]),
        .m1_addr    (ma[1]),
        .m1_wdata   (mw[1]),
        .m1_wstrb   (ms[1]),
        .m1_ready   (m1_ready),
        .m1_rdata   (m1_rdata),
        .s_valid    (s_valid),
        .s_instr    (s_instr),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .busy       (busy),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0; mi[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0;
        end
        s_ready = 1'b0;
        s_rdata = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v0, v1, sr;
        logic [31:0] srd;
        logic        e_busy, e_grant, e_sv, e_r0, e_r1;
        logic [31:0] e_rd0, e_rd1, e_saddr;
    } vec_t;

    function automatic vec_t mk(input logic v0, v1, sr, input logic [31:0] srd,
                                input logic eb, eg, esv, er0, er1,
                                input logic [31:0] erd0, erd1, esa);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.sr = sr; v.srd = srd;
        v.e_busy = eb; v.e_grant = eg; v.e_sv = esv; v.e_r0 = er0; v.e_r1 = er1;
        v.e_rd0 = erd0; v.e_rd1 = erd1; v.e_saddr = esa;
        return v;
    endfunction

    vec_t tbl[9];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        r0, r1;
        logic [31:0] rd0, rd1;
        logic        sv, sinstr;
        logic [31:0] saddr, swdata;
        logic [3:0]  swstrb;
        logic        busy, terr, grant;
    } exp_t;

    bit mdl_busy;
    int mdl_owner, mdl_age, mdl_prio;

    task automatic model_reset();
        mdl_busy = 0; mdl_owner = 0; mdl_age = 0; mdl_prio = 0;
    endtask

    function automatic bit model_timeout();
        return mdl_busy && !s_ready && mv[mdl_owner] && (mdl_age == TMO - 1);
    endfunction

    function automatic exp_t model_eval();
        exp_t e = '0;
        if (mdl_busy) begin
            int g = mdl_owner;
            e.busy   = 1'b1;
            e.grant  = (g == 1);
            e.sv     = mv[g];
            e.sinstr = mi[g];
            e.saddr  = ma[g];
            e.swdata = mw[g];
            e.swstrb = ms[g];
            if (s_ready || model_timeout()) begin
                logic [31:0] d = s_ready ? s_rdata : TRD;
                if (g == 0) begin e.r0 = 1'b1; e.rd0 = d; end
                else        begin e.r1 = 1'b1; e.rd1 = d; end
                e.terr = !s_ready;
            end
        end
        return e;
    endfunction

    task automatic model_step();
        if (!resetn) begin
            model_reset();
        end else if (mdl_busy) begin
            if (s_ready || model_timeout()) begin
                mdl_busy = 0;
                mdl_prio = 1 - mdl_owner;
            end else if (!mv[mdl_owner]) begin
                mdl_busy = 0;
            end else begin
                mdl_age++;
            end
        end else if (mv[0] || mv[1]) begin
            mdl_owner = (mv[0] && mv[1]) ? mdl_prio : (mv[1] ? 1 : 0);
            mdl_busy  = 1;
            mdl_age   = 0;
        end
    endtask

    task automatic check_exp(input exp_t e, input int cyc);
        string t = $sformatf("rnd%0d", cyc);
        check({t, ".m0_ready"}, m0_ready, e.r0);
        check({t, ".m1_ready"}, m1_ready, e.r1);
        check({t, ".m0_rdata"}, m0_rdata, e.rd0);
        check({t, ".m1_rdata"}, m1_rdata, e.rd1);
        check({t, ".s_valid"},  s_valid,  e.sv);
        check({t, ".s_instr"},  s_instr,  e.sinstr);
        check({t, ".s_addr"},   s_addr,   e.saddr);
        check({t, ".s_wdata"},  s_wdata,  e.swdata);
        check({t, ".s_wstrb"},  s_wstrb,  e.swstrb);
        check({t, ".busy"},     busy,     e.busy);
        check({t, ".timeout"},  timeout_err, e.terr);
        if (e.busy) check({t, ".grant"}, grant, e.grant);
    endtask

    bit   pend[2];
    exp_t ex;

    initial begin
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        settle();
        check("rst.busy", busy, 0);
        check("rst.grant", grant, 0);
        check("rst.s_valid", s_valid, 0);
        check("rst.readys", {m0_ready, m1_ready, timeout_err}, 0);
        check("rst.rdata", {m0_rdata, m1_rdata}, 0);
        resetn = 1'b1;
        tick();

        // Arbitration order and basic read; M0 re-requests right after its completion.
        tbl[0] = mk(1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0,         0);
        tbl[1] = mk(1, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 0,         32'h1000_0004);
        tbl[2] = mk(1, 1, 1, 32'h0000_0013, 1, 0, 1, 1, 0, 32'h13, 0,    32'h1000_0004);
        tbl[3] = mk(1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0,         0);
        tbl[4] = mk(1, 1, 0, 32'hCAFE_0000, 1, 1, 1, 0, 0, 0, 0,         32'h1000_0100);
        tbl[5] = mk(1, 1, 1, 32'h0000_0055, 1, 1, 1, 0, 1, 0, 32'h55,    32'h1000_0100);
        tbl[6] = mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0,         0);
        tbl[7] = mk(1, 0, 1, 32'h0000_0077, 1, 0, 1, 1, 0, 32'h77, 0,    32'h1000_0004);
        tbl[8] = mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0,         0);

        ma[0] = 32'h1000_0004; mi[0] = 1'b1;
        ma[1] = 32'h1000_0100;
        for (int i = 0; i < $size(tbl); i++) begin
            string t = $sformatf("tbl%0d", i);
            mv[0] = tbl[i].v0; mv[1] = tbl[i].v1;
            s_ready = tbl[i].sr; s_rdata = tbl[i].srd;
            settle();
            check({t, ".busy"},     busy,     tbl[i].e_busy);
            check({t, ".s_valid"},  s_valid,  tbl[i].e_sv);
            check({t, ".s_addr"},   s_addr,   tbl[i].e_saddr);
            check({t, ".m0_ready"}, m0_ready, tbl[i].e_r0);
            check({t, ".m1_ready"}, m1_ready, tbl[i].e_r1);
            check({t, ".m0_rdata"}, m0_rdata, tbl[i].e_rd0);
            check({t, ".m1_rdata"}, m1_rdata, tbl[i].e_rd1);
            check({t, ".timeout"},  timeout_err, 0);
            if (tbl[i].e_busy) check({t, ".grant"}, grant, tbl[i].e_grant);
            tick();
        end
        clear_inputs();

        // M1 write: slave-side fields must be exact copies.
        mv[1] = 1'b1; ma[1] = 32'h2000_0010; mw[1] = 32'hA5A5_5A5A; ms[1] = 4'b0011;
        settle();
        check("wr.idle_s_valid", s_valid, 0);
        tick();
        for (int k = 1; k <= 2; k++) begin
            s_ready = (k == 2); s_rdata = 32'h0BAD_F00D;
            settle();
            check("wr.s_valid", s_valid, 1);
            check("wr.grant",   grant,   1);
            check("wr.fields",  {s_addr, s_wdata}, {32'h2000_0010, 32'hA5A5_5A5A});
            check("wr.s_wstrb", s_wstrb, 4'b0011);
            check("wr.s_instr", s_instr, 0);
            check("wr.m1_ready", m1_ready, k == 2);
            check("wr.m0_ready", m0_ready, 0);
        end
        tick();
        clear_inputs();
        tick();

        // Watchdog expiry on the 8th BUSY cycle.
        mv[0] = 1'b1; ma[0] = 32'h3000_0000;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            settle();
            check($sformatf("tmo%0d.busy", k), busy, 1);
            check($sformatf("tmo%0d.m0_ready", k), m0_ready, k == TMO);
            check($sformatf("tmo%0d.m0_rdata", k), m0_rdata, (k == TMO) ? TRD : 32'h0);
            check($sformatf("tmo%0d.timeout", k), timeout_err, k == TMO);
            tick();
        end
        mv[0] = 1'b0;
        settle();
        check("tmo.after_busy", busy, 0);
        check("tmo.after_err", timeout_err, 0);
        tick();

        // s_ready arriving in the expiry cycle completes normally.
        mv[0] = 1'b1;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            s_ready = (k == TMO); s_rdata = 32'h1234_5678;
            settle();
            check($sformatf("col%0d.m0_ready", k), m0_ready, k == TMO);
            check($sformatf("col%0d.m0_rdata", k), m0_rdata, (k == TMO) ? 32'h1234_5678 : 32'h0);
            check($sformatf("col%0d.timeout", k), timeout_err, 0);
            tick();
        end
        clear_inputs();
        tick();

        // Reset in the middle of a transfer, then a lone M1 request.
        mv[0] = 1'b1; ma[0] = 32'h3000_0000;
        tick();
        settle();
        check("rstb.busy_before", busy, 1);
        resetn = 1'b0;
        mv[1] = 1'b1; ma[1] = 32'h4000_0000;
        tick();
        settle();
        check("rstb.busy", busy, 0);
        check("rstb.grant", grant, 0);
        check("rstb.s_bus", {s_valid, s_addr}, 0);
        check("rstb.readys", {m0_ready, m1_ready, timeout_err}, 0);
        mv[0] = 1'b0;
        resetn = 1'b1;
        tick();
        s_ready = 1'b1; s_rdata = 32'h0000_0042;
        settle();
        check("rstb.m1_grant", {busy, grant, s_valid}, 3'b111);
        check("rstb.m1_addr", s_addr, 32'h4000_0000);
        check("rstb.m1_ready", m1_ready, 1);
        check("rstb.m1_rdata", m1_rdata, 32'h42);
        tick();
        clear_inputs();

        // Randomized traffic against the reference model.
        resetn = 1'b0;
        tick();
        model_reset();
        resetn = 1'b1;
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(99) < 40) begin
                    pend[i] = 1;
                    ma[i] = $urandom;
                    mw[i] = $urandom;
                    ms[i] = $urandom_range(1) ? 4'($urandom) : 4'h0;
                    mi[i] = 1'($urandom_range(1));
                end else if (pend[i] && $urandom_range(99) < 2) begin
                    pend[i] = 0;
                end
                mv[i] = pend[i];
            end
            s_ready = ($urandom_range(99) < 25);
            s_rdata = $urandom;
            settle();
            ex = model_eval();
            check_exp(ex, c);
            if (ex.r0) pend[0] = 0;
            if (ex.r1) pend[1] = 0;
            model_step();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
